byte_serial_sub_64: RTL and testbench
=====================================

# byte_serial_sub_64

Multi-cycle 64-bit subtractor computing `diff = a - b - bin` one 8-bit slice per clock, least-significant slice first, with the borrow chained between slices in a register. It is the subtraction counterpart of the datapath's combinational adders. It trades latency for area and fits into pipelines through a valid/ready handshake on both input and output. Flags (borrow, signed overflow, zero) are produced alongside the result for downstream compare and branch logic.

## Interface
- `WIDTH`, 64, operand and result width; must be a multiple of `SLICE`
- `SLICE`, 8, bits processed per cycle; `NSL = WIDTH/SLICE` (8 by default)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `a`  in  WIDTH  minuend, sampled on input handshake
- `b`  in  WIDTH  subtrahend, sampled on input handshake
- `bin`  in  1  borrow in, sampled on input handshake
- `in_valid`  in  1  operands present
- `in_ready`  out  1  block can accept operands
- `diff`  out  WIDTH  result, meaningful only while `out_valid`=1
- `bout`  out  1  borrow out of MSB (1 = unsigned a < b+bin)
- `ovf`  out  1  signed (two's-complement) overflow
- `zero`  out  1  `diff` == 0
- `out_valid`  out  1  result and flags valid
- `out_ready`  in  1  consumer accepts result

## Operation
- FSM states:
  - IDLE: `in_ready`=1; on `in_valid`=1, capture `a`, `b`, `bin`; load carry = ~`bin`; slice index = 0; go to BUSY.
  - BUSY: each cycle, slice k computes `a[k] + ~b[k] + carry`. Write the slice result to `diff[k]` and the slice carry-out to the carry register; increment k. After slice NSL-1, go to DONE.
  - DONE: `out_valid`=1. On `out_ready`=1, go to IDLE.
- Flags are registered at the final slice:
  - `bout` = ~final carry
  - `ovf` = (a_msb != b_msb) && (diff_msb != a_msb)
  - `zero` = all slices zero, tracked as a sticky AND across slices
- `in_ready` = (state == IDLE) only. No new accept is possible in BUSY or DONE.
- In BUSY, `in_valid` is ignored and operands are not resampled.
- Reset (any state, any time): state = IDLE; `diff`, `bout`, `ovf`, `zero`, `out_valid` = 0; carry = 0; k = 0. `in_ready` reads 1 during and after reset.
- An operation in flight when reset asserts is dropped, with no partial result presented.

## Timing
- Input handshake completes at rising edge T (`in_valid` && `in_ready`).
- Slices 0..NSL-1 are processed at edges T+1 .. T+NSL.
- `out_valid` is high from edge T+NSL, i.e. 8-cycle latency by default.
- `out_valid`, `diff` and the flags remain stable until the edge where `out_ready`=1 is sampled. State is IDLE from the next cycle.
- `out_ready` held at 1 gives minimum initiation interval NSL+2 = 10 cycles.
- `out_ready` may be asserted before `out_valid` and has no effect outside DONE.
- No combinational path from any input to any output except `in_ready`, which is a state decode.

## Structure
- Shared package `arith_pkg`: `WIDTH`/`SLICE` defaults, derived `NSL`, and a state enum {IDLE, BUSY, DONE}.
- Sub-module `sub_slice_8`: combinational slice, inputs `x`, `y`, `cin`; outputs `d`, `cout`.
  - Carry-select internally: two ripple chains, for cin=0 and cin=1, plus a mux.
  - One instance, reused every cycle via slice-index muxing.

## Test plan
- a=5, b=3, bin=0 -> `diff`=2, `bout`=0, `ovf`=0, `zero`=0; `out_valid` rises exactly 8 cycles after accept.
- a=0, b=1, bin=0 -> `diff`=0xFFFF_FFFF_FFFF_FFFF, `bout`=1, `ovf`=0.
- a=0x8000_0000_0000_0000, b=1, bin=0 -> `diff`=0x7FFF_FFFF_FFFF_FFFF, `ovf`=1, `bout`=0.
- a=0x100, b=0xFF, bin=1 -> `diff`=0, `zero`=1, `bout`=0. This checks borrow crossing a slice boundary.
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid` while `in_valid` stays 1 with new operands.
  - Result and flags hold, `in_ready`=0, and the new operands are not taken.
  - Once `out_ready`=1, the next accept occurs one cycle later.
- Reset asserted during slice 4 -> all outputs 0 asynchronously and `in_ready`=1.
  - After release, a=10, b=4 yields `diff`=6 with normal latency.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: default datapath geometry and the
// serial-subtractor control states.
package arith_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int SLICE_DEF = 8;
    localparam int NSL_DEF   = WIDTH_DEF / SLICE_DEF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/sub_slice_8.sv
// Combinational subtract slice: d = x + ~y + cin, built as two precomputed
// ripple chains (cin=0 / cin=1) selected by the incoming carry.
module sub_slice_8 #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] d,
    output logic         cout
);

    logic [W-1:0] ny;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         c0;
    logic         c1;

    // NOTE: blocking assignments are correct here; c0/c1 are intentionally
    // re-assigned per bit to model the ripple, which only works in order.
    always_comb begin
        ny = ~y;
        c0 = 1'b0;
        c1 = 1'b1;
        d0 = '0;
        d1 = '0;
        for (int i = 0; i < W; i++) begin
            d0[i] = x[i] ^ ny[i] ^ c0;
            c0    = (x[i] & ny[i]) | (c0 & (x[i] ^ ny[i]));
            d1[i] = x[i] ^ ny[i] ^ c1;
            c1    = (x[i] & ny[i]) | (c1 & (x[i] ^ ny[i]));
        end
    end

    assign d    = cin ? d1 : d0;
    assign cout = cin ? c1 : c0;

endmodule

// File: rtl/byte_serial_sub_64.sv
// Multi-cycle subtractor: diff = a - b - bin, one slice per clock LSB first,
// with valid/ready handshakes and registered borrow/overflow/zero flags.
module byte_serial_sub_64
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NSL = WIDTH / SLICE;
    localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

    state_t state;
    state_t state_next;

    logic [SLICE-1:0] a_q    [NSL];
    logic [SLICE-1:0] b_q    [NSL];
    logic [SLICE-1:0] diff_q [NSL];
    logic [KW-1:0]    k;
    logic             carry;
    logic             zero_acc;

    logic [SLICE-1:0] slice_d;
    logic             slice_cout;
    logic             last_slice;
    logic             a_msb;
    logic             b_msb;

    // The single slice instance is time-shared via the slice index k.
    sub_slice_8 #(.W(SLICE)) u_slice (
        .x    (a_q[k]),
        .y    (b_q[k]),
        .cin  (carry),
        .d    (slice_d),
        .cout (slice_cout)
    );

    assign last_slice = (k == K_LAST);
    assign a_msb      = a_q[NSL-1][SLICE-1];
    assign b_msb      = b_q[NSL-1][SLICE-1];

    for (genvar g = 0; g < NSL; g++) begin : g_diff
        assign diff[g*SLICE +: SLICE] = diff_q[g];
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = BUSY;
            BUSY:    if (last_slice) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // NOTE: the per-slice arrays are reset explicitly because diff must read
    // zero during reset; a plain storage array would normally be left alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSL; i++) begin
                a_q[i]    <= '0;
                b_q[i]    <= '0;
                diff_q[i] <= '0;
            end
            k        <= '0;
            carry    <= 1'b0;
            zero_acc <= 1'b0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NSL; i++) begin
                            a_q[i] <= a[i*SLICE +: SLICE];
                            b_q[i] <= b[i*SLICE +: SLICE];
                        end
                        carry    <= ~bin;
                        k        <= '0;
                        zero_acc <= 1'b1;
                    end
                end
                BUSY: begin
                    diff_q[k] <= slice_d;
                    carry     <= slice_cout;
                    zero_acc  <= zero_acc & (slice_d == '0);
                    k         <= k + KW'(1);
                    if (last_slice) begin
                        k    <= '0;
                        bout <= ~slice_cout;
                        ovf  <= (a_msb != b_msb) && (slice_d[SLICE-1] != a_msb);
                        zero <= zero_acc & (slice_d == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_sub_64.sv
// Scoreboard bench for byte_serial_sub_64: the driver pushes reference
// results on each accept, the monitor pops and compares on each output.
module tb_byte_serial_sub_64;

    localparam int W   = 64;
    localparam int LAT = 8;
    localparam int II  = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          bin;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  diff;
    logic          bout;
    logic          ovf;
    logic          zero;
    logic          out_valid;
    logic          out_ready;
    logic          rdy_fix;
    logic          rdy_rand = 1'b0;
    logic          rand_mode;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   seen  = 1'b0;

    assign out_ready = rand_mode ? rdy_rand : rdy_fix;

    byte_serial_sub_64 dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #2;
        rdy_rand = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain wide arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mbin, input int acc);
        exp_t                e;
        logic [W:0]          u;
        logic signed [W+1:0] s;
        u = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        s = $signed({{2{ma[W-1]}}, ma}) - $signed({{2{mb[W-1]}}, mb})
            - $signed({{(W+1){1'b0}}, mbin});
        e.diff = u[W-1:0];
        e.bout = u[W];
        e.ovf  = (s < -(66'sd1 <<< (W-1))) || (s > ((66'sd1 <<< (W-1)) - 66'sd1));
        e.zero = (u[W-1:0] == '0);
        e.acc  = acc;
        return e;
    endfunction

    // Monitor: compares every cycle a result is presented, pops on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            seen = 1'b0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got diff=%h want no result", diff);
            end else begin
                if (!seen) check("latency", 64'(cyc - sb[0].acc), 64'(LAT));
                check("diff", diff, sb[0].diff);
                check("flags{bout,ovf,zero}", 64'({bout, ovf, zero}),
                      64'({sb[0].bout, sb[0].ovf, sb[0].zero}));
                seen = 1'b1;
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end else begin
            seen = 1'b0;
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tbin, output int acc);
        a        = ta;
        b        = tb_v;
        bin      = tbin;
        in_valid = 1'b1;
        acc      = -1;
        for (int n = 0; n < 100; n++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                sb.push_back(model(ta, tb_v, tbin, acc));
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (acc < 0) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept want accept within 100 cycles");
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) return;
        end
        total++;
        bad++;
        $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_diff"}, diff, 64'd0);
        check({tag, "_flags"}, 64'({bout, ovf, zero}), 64'd0);
    endtask

    initial begin
        int            acc0;
        int            acc1;
        int            c;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        logic          rbin;
        bit            got_valid;

        rst       = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        rdy_fix   = 1'b1;
        rand_mode = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Directed vectors; the first pair also measures the initiation interval.
        send(64'd5, 64'd3, 1'b0, acc0);
        send(64'd0, 64'd1, 1'b0, acc1);
        check("init_interval", 64'(acc1 - acc0), 64'(II));
        send(64'h8000_0000_0000_0000, 64'd1, 1'b0, acc0);
        send(64'h100, 64'hFF, 1'b1, acc0);
        drain();

        // Backpressure with new operands waiting on in_valid.
        @(posedge clk);
        #2;
        rdy_fix = 1'b0;
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, acc0);
        a        = 64'hFFFF_0000_FFFF_0000;
        b        = 64'h0000_FFFF_0000_FFFF;
        bin      = 1'b0;
        in_valid = 1'b1;
        got_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid) begin
                got_valid = 1'b1;
                break;
            end
        end
        check("bp_out_valid_seen", 64'(got_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #2;
        rdy_fix = 1'b1;
        c = cyc;
        send(64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b0, acc1);
        check("bp_accept_cycle", 64'(acc1 - c), 64'd2);
        drain();

        // Reset while slice 4 is being computed drops the operation.
        send(64'hDEAD_BEEF_0BAD_F00D, 64'h0123_4567_89AB_CDEF, 1'b0, acc0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(64'd10, 64'd4, 1'b0, acc0);
        drain();

        // Random operands with random consumer backpressure.
        @(posedge clk);
        #2;
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            rbin = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: begin rb = ra; rbin = 1'b0; end
                1: rb = {1'b0, rb[W-2:0]} | {ra[W-1] ^ 1'b1, {(W-1){1'b0}}};
                2: ra = '0;
                default: ;
            endcase
            send(ra, rb, rbin, acc0);
        end
        #1;
        rand_mode = 1'b0;
        drain();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
